// File: rtl/vfp_pkg.sv
// rtl/vfp_pkg.sv - shared mode type, default parameters and width helpers for vec_filter_pipe
package vfp_pkg;

   typedef enum logic [1:0] {
      VFP_FIR  = 2'd0,
      VFP_BYP  = 2'd1,
      VFP_EDGE = 2'd2,
      VFP_RSV  = 2'd3
   } vfp_mode_e;

   localparam int VFP_LANES_DEF  = 3;
   localparam int VFP_DATA_W_DEF = 18;
   localparam int VFP_COEF_W_DEF = 8;
   localparam int VFP_TAPS_DEF   = 3;
   localparam int VFP_SHIFT_DEF  = 4;

   // zero-extended pixel (DATA_W+1 signed) times a signed coefficient
   function automatic int vfp_prod_w(input int data_w, input int coef_w);
      return data_w + 1 + coef_w;
   endfunction

   // product width plus guard bits so the tap sum cannot overflow
   function automatic int vfp_sum_w(input int data_w, input int coef_w, input int taps);
      return vfp_prod_w(data_w, coef_w) + $clog2(taps);
   endfunction

endpackage

// File: rtl/vfp_lane.sv
// rtl/vfp_lane.sv - one colour lane: history, stage-2 products, stage-3 reduce/convert (VFP_SAT_EN clamps)
module vfp_lane
   import vfp_pkg::*;
#(
   parameter int DATA_W = VFP_DATA_W_DEF,
   parameter int COEF_W = VFP_COEF_W_DEF,
   parameter int TAPS   = VFP_TAPS_DEF,
   parameter int SHIFT  = VFP_SHIFT_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_adv,
   input  logic                   i_acc,
   input  logic                   i_sof,
   input  logic [DATA_W-1:0]      i_x,
   input  logic [TAPS*COEF_W-1:0] i_coef,
   input  vfp_mode_e              i_mode1,
   input  vfp_mode_e              i_mode2,
   output logic [DATA_W-1:0]      o_y
);

   localparam int PW = vfp_prod_w(DATA_W, COEF_W);
   localparam int SW = vfp_sum_w(DATA_W, COEF_W, TAPS);

   logic [DATA_W-1:0]    r_hist [1:TAPS-1];
   logic [DATA_W-1:0]    r_win  [0:TAPS-1];
   logic signed [PW-1:0] r_prod [0:TAPS-1];
   logic [DATA_W-1:0]    r_alt;
   logic [DATA_W-1:0]    r_y;

   logic signed [PW-1:0] w_prod [0:TAPS-1];
   logic [DATA_W-1:0]    w_alt;
   logic signed [SW-1:0] w_sum;
   logic signed [SW-1:0] w_shift;
   logic [DATA_W-1:0]    w_conv;

   assign o_y = r_y;

   // history moves only on accepted beats; a sof beat starts a fresh line
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 1; k < TAPS; k++) r_hist[k] <= '0;
      end else if (i_acc) begin
         r_hist[1] <= i_x;
         for (int k = 2; k < TAPS; k++) r_hist[k] <= i_sof ? '0 : r_hist[k-1];
      end
   end

   // stage 1: capture the tap window, with history read as zero on sof
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < TAPS; k++) r_win[k] <= '0;
      end else if (i_adv) begin
         r_win[0] <= i_x;
         for (int k = 1; k < TAPS; k++) r_win[k] <= i_sof ? '0 : r_hist[k];
      end
   end

   // stage-2 operands: signed per-tap products and the edge/bypass value
   always_comb begin
      for (int k = 0; k < TAPS; k++) begin
         w_prod[k] = $signed({{COEF_W{1'b0}}, 1'b0, r_win[k]})
                   * $signed({{(DATA_W+1){i_coef[k*COEF_W+COEF_W-1]}}, i_coef[k*COEF_W +: COEF_W]});
      end
      if (i_mode1 == VFP_EDGE) begin
         w_alt = (r_win[0] >= r_win[1]) ? (r_win[0] - r_win[1]) : (r_win[1] - r_win[0]);
      end else begin
         w_alt = r_win[0];
      end
   end

   // stage 2: register products and the non-FIR result
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < TAPS; k++) r_prod[k] <= '0;
         r_alt <= '0;
      end else if (i_adv) begin
         for (int k = 0; k < TAPS; k++) r_prod[k] <= w_prod[k];
         r_alt <= w_alt;
      end
   end

   // stage-3 reduce: guarded sum, floor shift, then clamp or wrap to DATA_W
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < TAPS; k++) begin
         w_sum = w_sum + $signed({{(SW-PW){r_prod[k][PW-1]}}, r_prod[k]});
      end
      w_shift = w_sum >>> SHIFT;
`ifdef VFP_SAT_EN
      if (w_shift[SW-1]) begin
         w_conv = '0;
      end else if (|w_shift[SW-2:DATA_W]) begin
         w_conv = '1;
      end else begin
         w_conv = w_shift[DATA_W-1:0];
      end
`else
      w_conv = DATA_W'(w_shift);
`endif
   end

   // stage 3: output register, held while the pipe is stalled
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_y <= '0;
      end else if (i_adv) begin
         r_y <= (i_mode2 == VFP_FIR) ? w_conv : r_alt;
      end
   end

endmodule

// File: rtl/vec_filter_pipe.sv
// rtl/vec_filter_pipe.sv - LANES-wide FIR/edge/bypass pixel pipe; define VFP_SAT_EN to clamp instead of wrap
module vec_filter_pipe
   import vfp_pkg::*;
#(
   parameter int LANES  = VFP_LANES_DEF,
   parameter int DATA_W = VFP_DATA_W_DEF,
   parameter int COEF_W = VFP_COEF_W_DEF,
   parameter int TAPS   = VFP_TAPS_DEF,
   parameter int SHIFT  = VFP_SHIFT_DEF
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_sof,
   input  logic [1:0]                in_mode,
   input  logic [LANES*DATA_W-1:0]   in_data,
   input  logic                      cfg_we,
   input  logic [$clog2(TAPS)-1:0]   cfg_idx,
   input  logic [COEF_W-1:0]         cfg_coef,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_sof,
   output logic [LANES*DATA_W-1:0]   out_data
);

   localparam logic [COEF_W-1:0] C_ID = COEF_W'(1 << SHIFT);

   logic              r_v1, r_v2, r_v3;
   logic              r_sof1, r_sof2, r_sof3;
   vfp_mode_e         r_mode1, r_mode2;
   logic [COEF_W-1:0] r_shadow [0:TAPS-1];
   logic [COEF_W-1:0] r_active [0:TAPS-1];

   logic                   w_adv;
   logic                   w_acc;
   logic [TAPS*COEF_W-1:0] w_coef;

   // the whole pipe moves together unless a finished beat is waiting downstream
   assign w_adv     = !(r_v3 && !out_ready);
   assign w_acc     = in_valid && w_adv;
   assign in_ready  = w_adv;
   assign out_valid = r_v3;
   assign out_sof   = r_sof3;

   // stage valid/sof/mode tags travel alongside the lane data
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_v3    <= 1'b0;
         r_sof1  <= 1'b0;
         r_sof2  <= 1'b0;
         r_sof3  <= 1'b0;
         r_mode1 <= VFP_FIR;
         r_mode2 <= VFP_FIR;
      end else if (w_adv) begin
         r_v1    <= w_acc;
         r_sof1  <= w_acc && in_sof;
         r_mode1 <= vfp_mode_e'(in_mode);
         r_v2    <= r_v1;
         r_sof2  <= r_sof1;
         r_mode2 <= r_mode1;
         r_v3    <= r_v2;
         r_sof3  <= r_sof2;
      end
   end

   // shadow takes writes any time; active copies the pre-write shadow on an accepted sof
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < TAPS; k++) begin
            r_shadow[k] <= (k == 0) ? C_ID : '0;
            r_active[k] <= (k == 0) ? C_ID : '0;
         end
      end else begin
         if (cfg_we && (int'(cfg_idx) < TAPS)) r_shadow[cfg_idx] <= cfg_coef;
         if (w_acc && in_sof) begin
            for (int k = 0; k < TAPS; k++) r_active[k] <= r_shadow[k];
         end
      end
   end

   // flatten the active bank for the lanes
   always_comb begin
      w_coef = '0;
      for (int k = 0; k < TAPS; k++) w_coef[k*COEF_W +: COEF_W] = r_active[k];
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      vfp_lane #(
         .DATA_W (DATA_W),
         .COEF_W (COEF_W),
         .TAPS   (TAPS),
         .SHIFT  (SHIFT)
      ) u_lane (
         .i_clk   (CLK),
         .i_rst   (RST),
         .i_adv   (w_adv),
         .i_acc   (w_acc),
         .i_sof   (in_sof),
         .i_x     (in_data[l*DATA_W +: DATA_W]),
         .i_coef  (w_coef),
         .i_mode1 (r_mode1),
         .i_mode2 (r_mode2),
         .o_y     (out_data[l*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_vec_filter_pipe.sv
// tb/tb_vec_filter_pipe.sv - directed and randomized bench for vec_filter_pipe against a behavioural model
module tb_vec_filter_pipe;

   localparam int LANES = 3;
   localparam int DW    = 18;
   localparam int CW    = 8;
   localparam int TAPS  = 3;
   localparam int SHIFT = 4;
   localparam int IW    = $clog2(TAPS);
   localparam longint MAXV = (longint'(1) << DW) - 1;
`ifdef VFP_SAT_EN
   localparam longint EXP_M10 = 0;
   localparam longint EXP_M14 = 0;
`else
   localparam longint EXP_M10 = (longint'(1) << DW) - 10;
   localparam longint EXP_M14 = (longint'(1) << DW) - 14;
`endif

   typedef struct {
      logic [LANES*DW-1:0] data;
      bit                  sof;
   } exp_t;

   logic                CLK;
   logic                RST;
   logic                in_valid;
   logic                in_ready;
   logic                in_sof;
   logic [1:0]          in_mode;
   logic [LANES*DW-1:0] in_data;
   logic                cfg_we;
   logic [IW-1:0]       cfg_idx;
   logic [CW-1:0]       cfg_coef;
   logic                out_valid;
   logic                out_ready;
   logic                out_sof;
   logic [LANES*DW-1:0] out_data;

   int     n_cmp  = 0;
   int     n_fail = 0;
   exp_t   exp_q[$];
   exp_t   mon_e;
   longint got0[$];
   longint shadow[TAPS];
   longint active[TAPS];
   longint hist[LANES][$];
   bit     hold_pend = 0;
   logic [LANES*DW-1:0] hold_data;
   bit     hold_sof;
   bit     rand_rdy = 0;

   vec_filter_pipe #(
      .LANES(LANES), .DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .SHIFT(SHIFT)
   ) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_mode(in_mode), .in_data(in_data),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_coef(cfg_coef),
      .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_data(out_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string nm, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   function automatic longint conv(input longint v);
`ifdef VFP_SAT_EN
      if (v < 0) return 0;
      if (v > MAXV) return MAXV;
      return v;
`else
      return v & MAXV;
`endif
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      for (int l = 0; l < LANES; l++) hist[l].delete();
      for (int k = 0; k < TAPS; k++) begin
         shadow[k] = (k == 0) ? (longint'(1) << SHIFT) : 0;
         active[k] = shadow[k];
      end
      hold_pend = 0;
   endfunction

   // one accepted beat: previous pixels of the line come from a per-lane list, newest first
   function automatic void model_accept();
      exp_t   e;
      longint x, y, s, p;
      if (in_sof) for (int k = 0; k < TAPS; k++) active[k] = shadow[k];
      e.sof  = in_sof;
      e.data = '0;
      for (int l = 0; l < LANES; l++) begin
         x = longint'(in_data[l*DW +: DW]);
         if (in_sof) hist[l].delete();
         case (in_mode)
            2'd0: begin
               s = active[0] * x;
               for (int k = 1; k < TAPS; k++) begin
                  p = (k - 1 < hist[l].size()) ? hist[l][k-1] : 0;
                  s += active[k] * p;
               end
               y = conv(s >>> SHIFT);
            end
            2'd2: begin
               p = (hist[l].size() > 0) ? hist[l][0] : 0;
               y = (x >= p) ? x - p : p - x;
            end
            default: y = x;
         endcase
         e.data[l*DW +: DW] = DW'(y);
         hist[l].push_front(x);
         if (hist[l].size() > TAPS) void'(hist[l].pop_back());
      end
      exp_q.push_back(e);
   endfunction

   // compare process: runs mid-cycle, checks handshake, held beats and every delivered beat
   always @(negedge CLK) begin
      if (RST) begin
         model_reset();
      end else begin
         check("in_ready_rule", in_ready, !(out_valid && !out_ready));
         if (hold_pend) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hold_data);
            check("hold_sof", out_sof, hold_sof);
         end
         hold_pend = 0;
         if (out_valid) begin
            if (out_ready) begin
               check("beat_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  mon_e = exp_q.pop_front();
                  check("out_data", out_data, mon_e.data);
                  check("out_sof", out_sof, mon_e.sof);
                  got0.push_back(longint'(out_data[DW-1:0]));
               end
            end else begin
               hold_pend = 1;
               hold_data = out_data;
               hold_sof  = out_sof;
            end
         end
         if (in_valid && in_ready) model_accept();
         if (cfg_we && int'(cfg_idx) < TAPS) shadow[cfg_idx] = longint'($signed(cfg_coef));
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_accept();
      int n   = 0;
      bit acc = 0;
      while (!acc && n < 200) begin
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
         @(negedge CLK);
         acc = in_ready;
         @(posedge CLK);
         #1;
         n++;
      end
      in_valid = 0;
      in_sof   = 0;
      if (!acc) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      end
   endtask

   task automatic send_vec(input bit sof, input int mode, input logic [LANES*DW-1:0] v);
      in_valid = 1;
      in_sof   = sof;
      in_mode  = mode[1:0];
      in_data  = v;
      wait_accept();
   endtask

   task automatic send(input bit sof, input int mode, input longint d0);
      send_vec(sof, mode, {DW'(d0 * 3), DW'(d0 + 7), DW'(d0)});
   endtask

   task automatic cfg(input int idx, input int coef);
      cfg_we   = 1;
      cfg_idx  = IW'(idx);
      cfg_coef = CW'(coef);
      step();
      cfg_we   = 0;
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 0;
      out_ready = 1;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
      end
   endtask

   task automatic check_seq(input string nm, input int n, input longint v0, input longint v1, input longint v2);
      longint v[3];
      v[0] = v0; v[1] = v1; v[2] = v2;
      check({nm, "_count"}, got0.size(), n);
      for (int i = 0; i < n && i < got0.size(); i++) check(nm, got0[i], v[i]);
   endtask

   initial begin
      int lat;
      int sent;
      int cyc;
      int cnt;
      bit acc;
      logic [LANES*DW-1:0] vec;

      RST = 1; in_valid = 0; in_sof = 0; in_mode = 0; in_data = '0;
      cfg_we = 0; cfg_idx = '0; cfg_coef = '0; out_ready = 1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sof", out_sof, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      RST = 0;
      step();

      // identity coefficients, latency of a lone beat, then a short stream
      got0.delete();
      send(1, 0, 100);
      lat = 1;
      while (!out_valid && lat < 10) begin
         step();
         lat++;
      end
      check("latency_edges", lat, 3);
      send(0, 0, 200);
      send(0, 0, 300);
      drain();
      check_seq("identity", 3, 100, 200, 300);

      // two-tap average
      cfg(0, 16); cfg(1, 16); cfg(2, 0);
      got0.delete();
      send(1, 0, 10); send(0, 0, 20); send(0, 0, 30);
      drain();
      check_seq("fir_16_16", 3, 10, 30, 50);

      // edge magnitude
      got0.delete();
      send(1, 2, 50); send(0, 2, 20);
      drain();
      check_seq("edge", 2, 50, 30, 0);

      // negative result: clamp or wrap
      cfg(0, -32); cfg(1, 0);
      got0.delete();
      send(1, 0, 5);
      drain();
      check_seq("neg_fir", 1, EXP_M10, 0, 0);

      // coefficient write on the same cycle as an accepted sof waits for the next sof
      got0.delete();
      cfg_we = 1; cfg_idx = IW'(0); cfg_coef = CW'(16);
      send(1, 0, 7);
      cfg_we = 0;
      send(1, 0, 7);
      drain();
      check_seq("cfg_on_sof", 2, EXP_M14, 7, 0);

      // downstream stall for 4 cycles mid-stream
      got0.delete();
      sent = 0; cyc = 0;
      in_mode = 2'd1;
      while (sent < 8 && cyc < 40) begin
         in_valid  = 1;
         in_sof    = (sent == 0);
         in_data   = {DW'(sent), DW'(sent + 1), DW'(1000 + sent)};
         out_ready = !(cyc >= 4 && cyc < 8);
         @(negedge CLK);
         acc = in_ready;
         if (cyc == 6) check("stall_in_ready", in_ready, 0);
         @(posedge CLK);
         #1;
         if (acc) sent++;
         cyc++;
      end
      in_valid = 0; in_sof = 0;
      drain();
      check("stall_count", got0.size(), 8);
      for (int i = 0; i < 8 && i < got0.size(); i++) check("stall_order", got0[i], 1000 + i);

      // randomized traffic, coefficients and backpressure
      rand_rdy = 1;
      for (int it = 0; it < 500; it++) begin
         cnt = $urandom_range(0, 9);
         out_ready = ($urandom_range(0, 3) != 0);
         if (cnt == 0) begin
            cfg($urandom_range(0, TAPS - 1), $urandom_range(0, 255));
         end else if (cnt == 1) begin
            step();
         end else begin
            for (int l = 0; l < LANES; l++) vec[l*DW +: DW] = DW'($urandom);
            if ($urandom_range(0, 7) == 0) begin
               cfg_we   = 1;
               cfg_idx  = IW'($urandom_range(0, TAPS - 1));
               cfg_coef = CW'($urandom_range(0, 255));
            end
            send_vec($urandom_range(0, 7) == 0, $urandom_range(0, 3), vec);
            cfg_we = 0;
         end
      end
      rand_rdy = 0;
      drain();
      check("random_left", exp_q.size(), 0);

      // reset with three beats in flight
      send(1, 0, 11); send(0, 0, 12); send(0, 0, 13);
      RST = 1;
      step(); step();
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_in_ready", in_ready, 1);
      RST = 0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid) cnt++;
      end
      check("midrst_stale_beats", cnt, 0);
      got0.delete();
      send(1, 0, 123);
      drain();
      check_seq("post_rst_identity", 1, 123, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
